// File: rtl/fp_sum_result_buffer_if.sv
// ----------------------------------------------------------------------------
// fp_sum_result_buffer_if
// Stream bundle for the FP summator result buffer.
//   s_valid / s_ready / a / b          : operand-pair stream into the buffer
//   m_valid / m_ready / m_answer / m_status : result stream out of the buffer
// Modports:
//   slave  : the buffer's view (accepts operands, presents results)
//   master : the producer/consumer view (drives operands, drains results)
// ----------------------------------------------------------------------------
interface fp_sum_result_buffer_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_answer;
    logic [1:0]  m_status;

    modport slave (
        input  s_valid, a, b, m_ready,
        output s_ready, m_valid, m_answer, m_status
    );

    modport master (
        output s_valid, a, b, m_ready,
        input  s_ready, m_valid, m_answer, m_status
    );
endinterface

// File: rtl/fp_sum_result_buffer.sv
// ----------------------------------------------------------------------------
// fp_sum_result_buffer
// Stream adapter and result buffer around a non-stalling pipelined FP
// summator. Operand pairs pass straight through to the summator; a valid
// pipe matched to the summator latency marks the cycle each answer arrives,
// and every answer/status pair is captured into a first-word-fall-through
// FIFO. Admission is credit based so a capture always finds a free slot.
// Ports:
//   clk_i, rst_i        : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : operand stream in, result stream out
//   sum_a_o, sum_b_o    : operands to the summator (combinational copy)
//   sum_vld_o           : issue strobe to the summator
//   sum_answer_i        : summator answer, valid LATENCY cycles after issue
//   sum_status_i        : summator status, alongside the answer
//   level_o             : entries currently held in the FIFO
//   inflight_o          : operations issued and not yet captured
//   ovf_o               : sticky, capture attempted into a full FIFO
// ----------------------------------------------------------------------------
module fp_sum_result_buffer #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    fp_sum_result_buffer_if.slave      bus,
    output logic [31:0]                sum_a_o,
    output logic [31:0]                sum_b_o,
    output logic                       sum_vld_o,
    input  logic [31:0]                sum_answer_i,
    input  logic [1:0]                 sum_status_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [$clog2(LATENCY):0]   inflight_o,
    output logic                       ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(LATENCY) + 1;
    localparam int SW = ((LW > IW) ? LW : IW) + 1;

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [IW-1:0] INF_ONE = 1;

    logic [LATENCY-1:0] vld_p;
    logic [IW-1:0]      inflight;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [LW-1:0]      level;
    logic [33:0]        mem [DEPTH];
    logic [33:0]        head;
    logic [SW-1:0]      credit;
    logic               issue;
    logic               capture;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               ovf;

    // Issue: operands and strobe pass straight through to the summator
    // Credit counts both stored and in-flight results, so admission only
    // looks at registered state and never at s_valid or m_ready.
    assign level         = wr_ptr - rd_ptr;
    assign full          = (level == LW'(DEPTH));
    assign credit        = SW'(level) + SW'(inflight);
    assign bus.s_ready   = rst_i & (credit < SW'(DEPTH));
    assign issue         = bus.s_valid & bus.s_ready;
    assign sum_a_o       = bus.a;
    assign sum_b_o       = bus.b;
    assign sum_vld_o     = issue;

    // Valid pipe: last tap marks the summator answer as valid this cycle
    assign capture = vld_p[LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | LATENCY'(issue);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + INF_ONE;
                2'b01:   inflight <= inflight - INF_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    // Result FIFO: capture at the edge after the last pipe tap
    // A pop in the same cycle frees the head slot, so writing into a full
    // FIFO is safe then; otherwise the write is dropped and flagged.
    assign bus.m_valid = (level != '0);
    assign pop         = bus.m_valid & bus.m_ready;
    assign wr_en       = capture & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {sum_status_i, sum_answer_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (capture & full & ~pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Head read is combinational from storage and forced to zero when empty
    assign head         = mem[rd_ptr[AW-1:0]];
    assign bus.m_answer = bus.m_valid ? head[31:0]  : 32'd0;
    assign bus.m_status = bus.m_valid ? head[33:32] : 2'd0;

    assign level_o    = level;
    assign inflight_o = inflight;
    assign ovf_o      = ovf;
endmodule

// File: tb/tb_fp_sum_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_fp_sum_result_buffer
// Bench for fp_sum_result_buffer. A behavioural summator (integer-valued
// single-precision add, status = low two bits of the integer sum) sits on
// the summator port with the configured latency. A scoreboard queue holds
// every accepted operation with the cycle its result becomes visible; the
// expected FIFO level, in-flight count, credit and head data all follow
// from that queue.
// ----------------------------------------------------------------------------
module tb_fp_sum_result_buffer;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;

    logic                      clk_i;
    logic                      rst_i;
    logic [31:0]               sum_a_o;
    logic [31:0]               sum_b_o;
    logic                      sum_vld_o;
    logic [31:0]               sum_answer_i;
    logic [1:0]                sum_status_i;
    logic [$clog2(DEPTH):0]    level_o;
    logic [$clog2(LATENCY):0]  inflight_o;
    logic                      ovf_o;

    fp_sum_result_buffer_if bus ();

    fp_sum_result_buffer #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus.slave),
        .sum_a_o      (sum_a_o),
        .sum_b_o      (sum_b_o),
        .sum_vld_o    (sum_vld_o),
        .sum_answer_i (sum_answer_i),
        .sum_status_i (sum_status_i),
        .level_o      (level_o),
        .inflight_o   (inflight_o),
        .ovf_o        (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Integer <-> single-precision helpers for small non-negative integers
    function automatic logic [31:0] i2f(input int unsigned n);
        int          p;
        logic [31:0] m;
        logic [31:0] nv;
        nv = n;
        if (nv == 0) return 32'd0;
        p = 31;
        while (nv[p] == 1'b0) p--;
        m = nv << (23 - p);
        return {1'b0, 8'(p + 127), m[22:0]};
    endfunction

    function automatic int unsigned f2i(input logic [31:0] x);
        int          e;
        logic [31:0] m;
        if (x[30:0] == 31'd0) return 0;
        e = int'(x[30:23]) - 127;
        if (e < 0 || e > 23) return 0;
        m = {8'd0, 1'b1, x[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic logic [33:0] sum_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = f2i(a) + f2i(b);
        return {s[1:0], i2f(s)};
    endfunction

    // Behavioural summator: fixed latency, never stalls, not reset
    logic [33:0] spipe [LATENCY];
    always @(posedge clk_i) begin
        spipe[0] <= sum_ref(sum_a_o, sum_b_o);
        for (int i = 1; i < LATENCY; i++) spipe[i] <= spipe[i-1];
    end
    assign sum_answer_i = spipe[LATENCY-1][31:0];
    assign sum_status_i = spipe[LATENCY-1][33:32];

    // Scoreboard and per-cycle compare
    typedef struct {
        logic [33:0] data;
        int          rdy;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;

    initial begin
        forever begin
            int          nlev;
            int          ninf;
            logic        e_srdy;
            logic        e_mvld;
            logic [33:0] e_head;
            @(negedge clk_i);
            cyc++;
            if (!rst_i) begin
                q.delete();
                chk("rst_s_ready", bus.s_ready, 0);
                chk("rst_sum_vld", sum_vld_o, 0);
                chk("rst_m_valid", bus.m_valid, 0);
                chk("rst_m_answer", bus.m_answer, 0);
                chk("rst_m_status", bus.m_status, 0);
                chk("rst_level", level_o, 0);
                chk("rst_inflight", inflight_o, 0);
                chk("rst_ovf", ovf_o, 0);
            end else begin
                nlev = 0;
                foreach (q[i]) if (q[i].rdy <= cyc) nlev++;
                ninf   = q.size() - nlev;
                e_srdy = (q.size() < DEPTH);
                e_mvld = (nlev > 0);
                e_head = e_mvld ? q[0].data : 34'd0;
                chk("cmp_s_ready", bus.s_ready, e_srdy);
                chk("cmp_sum_vld", sum_vld_o, bus.s_valid & e_srdy);
                chk("cmp_sum_a", sum_a_o, bus.a);
                chk("cmp_sum_b", sum_b_o, bus.b);
                chk("cmp_m_valid", bus.m_valid, e_mvld);
                chk("cmp_m_answer", bus.m_answer, e_head[31:0]);
                chk("cmp_m_status", bus.m_status, e_head[33:32]);
                chk("cmp_level", level_o, nlev);
                chk("cmp_inflight", inflight_o, ninf);
                chk("cmp_ovf", ovf_o, 0);
                if (e_mvld && bus.m_ready) void'(q.pop_front());
                if (bus.s_valid && e_srdy) begin
                    q.push_back('{data: sum_ref(bus.a, bus.b), rdy: cyc + LATENCY + 1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        int issued;
        int seen;
        rst_i       = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("reset_level", level_o, 0);
        chk("reset_s_ready", bus.s_ready, 0);
        chk("reset_m_valid", bus.m_valid, 0);
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("release_s_ready", bus.s_ready, 1);

        // Single op: 1.0 + 2.0 = 3.0
        tick();
        bus.s_valid = 1'b1;
        bus.a       = 32'h3F800000;
        bus.b       = 32'h40000000;
        bus.m_ready = 1'b1;
        @(negedge clk_i);
        chk("single_s_ready", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        for (int k = 1; k <= LATENCY + 2; k++) begin
            @(negedge clk_i);
            chk("single_m_valid", bus.m_valid, (k == LATENCY + 1));
            if (k == LATENCY + 1) begin
                chk("single_answer", bus.m_answer, 32'h40400000);
                chk("single_status", bus.m_status, 2'b11);
            end
            if (k == LATENCY + 2) chk("single_level_after", level_o, 0);
            tick();
        end

        // Back-to-back stream: k.0 + 1.0 for k = 1..20
        for (int j = 0; j <= 20 + LATENCY; j++) begin
            bus.s_valid = (j < 20);
            bus.a       = i2f(j + 1);
            bus.b       = 32'h3F800000;
            @(negedge clk_i);
            if (j < 20) chk("stream_s_ready", bus.s_ready, 1);
            chk("stream_m_valid", bus.m_valid, (j >= LATENCY + 1));
            if (j >= LATENCY + 1) chk("stream_answer", bus.m_answer, i2f(j - LATENCY + 1));
            if (j == LATENCY + 1) chk("stream_first", bus.m_answer, 32'h40000000);
            if (j == 20 + LATENCY) chk("stream_last", bus.m_answer, 32'h41A80000);
            tick();
        end

        // Backpressure: consumer stalled, producer always valid
        bus.m_ready = 1'b0;
        issued = 0;
        for (int j = 0; j < 20; j++) begin
            bus.s_valid = 1'b1;
            bus.a       = i2f(100 + j);
            bus.b       = 32'h3F800000;
            @(negedge clk_i);
            if (bus.s_ready) issued++;
            tick();
        end
        chk("bp_issues", issued, DEPTH);
        @(negedge clk_i);
        chk("bp_s_ready", bus.s_ready, 0);
        chk("bp_level", level_o, 8);
        chk("bp_inflight", inflight_o, 0);
        chk("bp_ovf", ovf_o, 0);
        tick();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk_i);
        chk("bp_pop_m_valid", bus.m_valid, 1);
        chk("bp_pop_s_ready", bus.s_ready, 0);
        tick();
        bus.m_ready = 1'b0;
        @(negedge clk_i);
        chk("bp_after_pop_s_ready", bus.s_ready, 1);
        chk("bp_after_pop_level", level_o, 7);

        // Full push/pop: level 7 + 1 in flight, pop in the capture cycle
        tick();
        bus.s_valid = 1'b1;
        bus.a       = i2f(500);
        bus.b       = 32'h3F800000;
        @(negedge clk_i);
        chk("full_issue_s_ready", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        repeat (LATENCY - 1) tick();
        bus.m_ready = 1'b1;
        @(negedge clk_i);
        chk("full_pre_level", level_o, 7);
        chk("full_pre_inflight", inflight_o, 1);
        tick();
        bus.m_ready = 1'b0;
        @(negedge clk_i);
        chk("full_post_level", level_o, 7);
        chk("full_post_inflight", inflight_o, 0);
        chk("full_post_head", bus.m_answer, 32'h42CE0000);
        chk("full_post_status", bus.m_status, 2'b11);
        tick();
        bus.m_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk_i);
        chk("full_drained", level_o, 0);

        // Reset mid-flight: 2 results stored, 3 in flight
        tick();
        bus.m_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bus.s_valid = 1'b1;
            bus.a       = i2f(40 + j);
            tick();
        end
        bus.s_valid = 1'b0;
        repeat (LATENCY + 2) tick();
        for (int j = 0; j < 3; j++) begin
            bus.s_valid = 1'b1;
            bus.a       = i2f(60 + j);
            tick();
        end
        bus.s_valid = 1'b0;
        @(negedge clk_i);
        chk("mid_level", level_o, 2);
        chk("mid_inflight", inflight_o, 3);
        #2;
        bus.s_valid = 1'b1;
        rst_i       = 1'b0;
        #1;
        chk("async_s_ready", bus.s_ready, 0);
        chk("async_sum_vld", sum_vld_o, 0);
        chk("async_m_valid", bus.m_valid, 0);
        chk("async_m_answer", bus.m_answer, 0);
        chk("async_m_status", bus.m_status, 0);
        chk("async_level", level_o, 0);
        chk("async_inflight", inflight_o, 0);
        chk("async_ovf", ovf_o, 0);
        tick();
        bus.s_valid = 1'b0;
        tick();
        rst_i       = 1'b1;
        bus.m_ready = 1'b1;
        seen = 0;
        for (int j = 0; j < LATENCY + 4; j++) begin
            @(negedge clk_i);
            if (bus.m_valid) seen++;
            tick();
        end
        chk("stale_results", seen, 0);

        // Random traffic against the scoreboard
        issued = 0;
        for (int j = 0; j < 60000 && issued < 10000; j++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            bus.a       = i2f($urandom_range(0, 5000));
            bus.b       = i2f($urandom_range(0, 5000));
            @(negedge clk_i);
            if (bus.s_valid && bus.s_ready) issued++;
            tick();
        end
        chk("rand_issued", issued, 10000);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk_i);
            if (level_o == 0 && inflight_o == 0) break;
            tick();
        end
        chk("rand_drain_level", level_o, 0);
        chk("rand_drain_inflight", inflight_o, 0);
        chk("rand_ovf", ovf_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
